// File: rtl/load_value_predictor.sv
// ---------------------------------------------------------------------------
// load_value_predictor
//
// Last-value load predictor with an architectural register snapshot bank.
// A direct-mapped table of {valid, tag, value} supplies a predicted load value
// when a load starts. When the real cache data arrives, the predictor reports
// either a correct prediction (done) or a recovery request (en_recover), and
// writes the real value back into the table. An independent snapshot bank
// captures the whole register file so the core can roll back after a
// misprediction.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   vp_en          start a prediction for addr
//   addr           lookup key (index = addr[INDEX_BITS+1:2], tag = upper bits)
//   d_cache_valid  real load data available
//   d_cache_data   real loaded value
//   out            registered predicted value
//   done           one-cycle pulse: prediction was correct
//   en_recover     one-cycle pulse: misprediction, restore snapshot
//   take_snapshot  capture request (level, held until snap_done)
//   regs_in        live register file
//   regs_snapshot  captured register file
//   snap_done      one-cycle pulse: capture complete
// ---------------------------------------------------------------------------
module load_value_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int NUM_REGS   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 vp_en,
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic                                 d_cache_valid,
    input  logic [DATA_WIDTH-1:0]                d_cache_data,
    output logic [DATA_WIDTH-1:0]                out,
    output logic                                 done,
    output logic                                 en_recover,
    input  logic                                 take_snapshot,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot,
    output logic                                 snap_done
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]            state;

    // Table storage: only the valid bits need a reset; tag/value are
    // meaningless while the matching valid bit is clear.
    logic [ENTRIES-1:0]    tbl_valid;
    logic [TAG_W-1:0]      tbl_tag   [ENTRIES];
    logic [DATA_WIDTH-1:0] tbl_value [ENTRIES];

    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_W-1:0]      lat_tag;
    logic                  lat_hit;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic                  lookup_hit;
    logic                  resolve;
    logic                  snap_latch;

    assign index      = addr[INDEX_BITS+1:2];
    assign tag        = addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lookup_hit = tbl_valid[index] && (tbl_tag[index] == tag);

    // Resolution happens only in WAIT; reset wins so an aborted load never
    // writes the table.
    assign resolve    = rst_n && (state == WAIT) && d_cache_valid;

    // Predictor FSM and control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tbl_valid  <= '0;
            out        <= '0;
            done       <= 1'b0;
            en_recover <= 1'b0;
            lat_index  <= '0;
            lat_tag    <= '0;
            lat_hit    <= 1'b0;
        end else begin
            done       <= 1'b0;
            en_recover <= 1'b0;
            if (state == IDLE) begin
                // d_cache_valid is ignored here, even when it coincides with vp_en.
                if (vp_en) begin
                    lat_index <= index;
                    lat_tag   <= tag;
                    lat_hit   <= lookup_hit;
                    out       <= lookup_hit ? tbl_value[index] : '0;
                    state     <= WAIT;
                end
            end else begin
                // vp_en is ignored while a prediction is outstanding.
                if (d_cache_valid) begin
                    // A miss predicted 0; it always recovers even if data is 0.
                    if (lat_hit && (d_cache_data == out)) begin
                        done <= 1'b1;
                    end else begin
                        en_recover <= 1'b1;
                    end
                    tbl_valid[lat_index] <= 1'b1;
                    state                <= IDLE;
                end
            end
        end
    end

    // Table data write
    always_ff @(posedge clk) begin
        if (resolve) begin
            tbl_tag[lat_index]   <= lat_tag;
            tbl_value[lat_index] <= d_cache_data;
        end
    end

    // Snapshot bank: one capture per assertion of take_snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_snapshot <= '0;
            snap_latch    <= 1'b0;
            snap_done     <= 1'b0;
        end else begin
            snap_done <= 1'b0;
            if (take_snapshot && !snap_latch) begin
                regs_snapshot <= regs_in;
                snap_latch    <= 1'b1;
                snap_done     <= 1'b1;
            end else if (!take_snapshot) begin
                snap_latch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_value_predictor.sv
module tb_load_value_predictor;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   vp_en;
    logic [AW-1:0]          addr;
    logic                   d_cache_valid;
    logic [DW-1:0]          d_cache_data;
    logic [DW-1:0]          out;
    logic                   done;
    logic                   en_recover;
    logic                   take_snapshot;
    logic [NR-1:0][DW-1:0]  regs_in;
    logic [NR-1:0][DW-1:0]  regs_snapshot;
    logic                   snap_done;

    load_value_predictor #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_BITS(6), .NUM_REGS(NR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vp_en(vp_en), .addr(addr),
        .d_cache_valid(d_cache_valid), .d_cache_data(d_cache_data),
        .out(out), .done(done), .en_recover(en_recover),
        .take_snapshot(take_snapshot), .regs_in(regs_in),
        .regs_snapshot(regs_snapshot), .snap_done(snap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] observed);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.val) passed++;
            else $error("FAIL %s: observed %0h required %0h", e.tag, observed, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a prediction and check the registered predicted value.
    task automatic predict(input logic [31:0] a, input logic [31:0] exp_out, input string tag);
        vp_en = 1'b1;
        addr  = a;
        push({tag, "_out"}, exp_out);
        tick();
        vp_en = 1'b0;
        pop_check(out);
    endtask

    // Deliver the real data; check the pulse and that it lasts one cycle.
    task automatic resolve(input logic [31:0] data, input logic exp_done,
                           input logic exp_rec, input string tag);
        d_cache_valid = 1'b1;
        d_cache_data  = data;
        push({tag, "_pulse"}, {30'd0, exp_done, exp_rec});
        tick();
        d_cache_valid = 1'b0;
        pop_check({30'd0, done, en_recover});
        push({tag, "_pulse_end"}, 32'd0);
        tick();
        pop_check({30'd0, done, en_recover});
    endtask

    initial begin
        rst_n         = 1'b0;
        vp_en         = 1'b0;
        addr          = '0;
        d_cache_valid = 1'b0;
        d_cache_data  = '0;
        take_snapshot = 1'b0;
        regs_in       = '0;
        tick();
        tick();

        // Reset state
        push("rst_out", 32'd0);        pop_check(out);
        push("rst_pulses", 32'd0);     pop_check({29'd0, done, en_recover, snap_done});
        push("rst_snap_r5", 32'd0);    pop_check(regs_snapshot[5]);
        rst_n = 1'b1;
        tick();

        // Cold miss, then repeat hit
        predict(32'h100, 32'h0, "cold");
        resolve(32'hDEAD, 1'b0, 1'b1, "cold");
        predict(32'h100, 32'hDEAD, "hit");
        resolve(32'hDEAD, 1'b1, 1'b0, "hit");

        // Value change
        predict(32'h100, 32'hDEAD, "chg");
        resolve(32'hBEEF, 1'b0, 1'b1, "chg");
        predict(32'h100, 32'hBEEF, "chg2");
        resolve(32'hBEEF, 1'b1, 1'b0, "chg2");

        // Alias: 0x500 shares index 0 with 0x100, different tag
        predict(32'h500, 32'h0, "alias");
        resolve(32'h1234, 1'b0, 1'b1, "alias");
        predict(32'h500, 32'h1234, "alias_hit");
        resolve(32'h1234, 1'b1, 1'b0, "alias_hit");
        predict(32'h100, 32'h0, "alias_evict");
        resolve(32'h77, 1'b0, 1'b1, "alias_evict");

        // d_cache_valid alone in IDLE is ignored
        d_cache_valid = 1'b1;
        d_cache_data  = 32'h77;
        push("idle_dcv", 32'd0);
        tick();
        d_cache_valid = 1'b0;
        pop_check({30'd0, done, en_recover});

        // vp_en with d_cache_valid in IDLE starts only; vp_en in WAIT ignored
        vp_en         = 1'b1;
        d_cache_valid = 1'b1;
        addr          = 32'h100;
        d_cache_data  = 32'h77;
        push("start_only_out", 32'h77);
        push("start_only_pulse", 32'd0);
        tick();
        d_cache_valid = 1'b0;
        addr          = 32'h500;
        pop_check(out);
        pop_check({30'd0, done, en_recover});
        push("wait_vp_out", 32'h77);
        tick();
        vp_en = 1'b0;
        pop_check(out);
        resolve(32'h77, 1'b1, 1'b0, "after_wait");

        // Snapshot held three cycles, regs changed mid-hold
        for (int i = 0; i < NR; i++) regs_in[i] = 32'(i * 4);
        take_snapshot = 1'b1;
        push("snap_done1", 32'd1);
        tick();
        pop_check({31'd0, snap_done});
        for (int i = 0; i < NR; i++) begin
            push($sformatf("snap_r%0d", i), 32'(i * 4));
            pop_check(regs_snapshot[i]);
        end
        for (int i = 0; i < NR; i++) regs_in[i] = 32'(i * 4 + 1);
        push("snap_done2", 32'd0);
        tick();
        pop_check({31'd0, snap_done});
        push("snap_done3", 32'd0);
        tick();
        pop_check({31'd0, snap_done});
        push("snap_hold_r7", 32'd28);
        pop_check(regs_snapshot[7]);
        take_snapshot = 1'b0;
        tick();

        // Recapture after release picks up new values
        take_snapshot = 1'b1;
        push("recap_done", 32'd1);
        tick();
        take_snapshot = 1'b0;
        pop_check({31'd0, snap_done});
        push("recap_r7", 32'd29);
        pop_check(regs_snapshot[7]);

        // Reset in WAIT aborts without pulse or table write
        predict(32'h100, 32'h77, "pre_rst");
        rst_n         = 1'b0;
        d_cache_valid = 1'b1;
        d_cache_data  = 32'h55;
        push("rst_wait_pulse", 32'd0);
        tick();
        pop_check({30'd0, done, en_recover});
        push("rst_wait_snap", 32'd0);
        pop_check(regs_snapshot[7]);
        rst_n         = 1'b1;
        d_cache_valid = 1'b0;
        tick();
        predict(32'h100, 32'h0, "post_rst");
        resolve(32'h55, 1'b0, 1'b1, "post_rst");

        total++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: observed %0d leftover required 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
